// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch front end for the dual-issue pipeline. Drives
//            the instruction ROM word address, captures the instruction pair
//            the ROM returns one cycle later, and buffers pairs in a small
//            FIFO toward decode with a valid/ready handshake. Branch/JAL
//            redirects flush buffered and in-flight pairs.
//
// Ports    : clk            - single clock, all state updates on rising edge
//            rst            - synchronous active-high reset
//            rom_addr       - ROM word index (PC >> 2), combinational from PC
//            rom_instr1     - ROM word at rom_addr, one cycle after address
//            rom_instr2     - ROM word at rom_addr+1, same timing
//            redirect_valid - redirect request from EX (taken branch / JAL)
//            redirect_pc    - byte target, bits [ADDR_W+1:2] used
//            dec_valid      - head pair available
//            dec_ready      - decode accepts head pair
//            dec_instr1     - older instruction of head pair
//            dec_instr2     - younger instruction of head pair
//            dec_pc         - byte PC of dec_instr1
//            perf_*         - (FETCH_QUEUE_PERF_EN only) saturating counters
//
// Options  : FETCH_QUEUE_PERF_EN - adds perf_stall_cycles, perf_empty_cycles
//            and perf_redirects 32-bit saturating counters.
//
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr1,
    input  logic [31:0]       rom_instr2,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_instr1,
    output logic [31:0]       dec_instr2,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]       dec_pc,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_empty_cycles,
    output logic [31:0]       perf_redirects
`else
    output logic [31:0]       dec_pc
`endif
);

    localparam int                PTR_W       = $clog2(DEPTH);
    localparam logic [31:0]       c_NOP       = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] c_PC_LAST   = {ADDR_W{1'b1}};
    localparam logic [PTR_W:0]    c_DEPTH_CNT = (PTR_W+1)'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_pc;

    logic [31:0]       r_mem_i1 [DEPTH];
    logic [31:0]       r_mem_i2 [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    logic [PTR_W:0]    w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_next_pc;
    logic [31:0]       w_cap_i2;
    logic              w_unused_pc_bits;

    // In-flight request reserves a slot; a same-cycle pop is deliberately not
    // credited so the issue decision never depends on dec_ready.
    assign w_occupancy = r_count + {{PTR_W{1'b0}}, r_req_valid};
    assign w_issue     = !redirect_valid && (w_occupancy < c_DEPTH_CNT);
    assign w_push      = r_req_valid && !redirect_valid;
    assign w_pop       = dec_valid && dec_ready && !redirect_valid;

    // The last ROM word has no successor, so the next pair starts at 0 rather
    // than at word 1.
    assign w_next_pc = (r_fetch_pc == c_PC_LAST) ? '0 : r_fetch_pc + ADDR_W'(2);

    // rom[addr+1] is out of range for the last word; pad with a NOP.
    assign w_cap_i2 = (r_req_pc == c_PC_LAST) ? c_NOP : rom_instr2;

    assign w_unused_pc_bits = ^{redirect_pc[31:ADDR_W+2], redirect_pc[1:0]};

    assign rom_addr = r_fetch_pc;

    // ------------------------------------------------------------------------
    // Fetch PC and in-flight request
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= '0;
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc  <= redirect_pc[ADDR_W+1:2];
            r_req_valid <= 1'b0;
        end else begin
            r_req_valid <= w_issue;
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= w_next_pc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and count
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_i1[r_wptr] <= rom_instr1;
            r_mem_i2[r_wptr] <= w_cap_i2;
            r_mem_pc[r_wptr] <= r_req_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Decode-side outputs
    // ------------------------------------------------------------------------
    assign dec_valid  = (r_count != '0);
    assign dec_instr1 = dec_valid ? r_mem_i1[r_rptr] : c_NOP;
    assign dec_instr2 = dec_valid ? r_mem_i2[r_rptr] : c_NOP;
    assign dec_pc     = dec_valid ?
                        {{(30-ADDR_W){1'b0}}, r_mem_pc[r_rptr], 2'b00} : 32'h0;

`ifdef FETCH_QUEUE_PERF_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_empty;
    logic [31:0] r_perf_redir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_empty <= '0;
            r_perf_redir <= '0;
        end else begin
            if (dec_valid && !dec_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (!dec_valid && (r_perf_empty != '1)) begin
                r_perf_empty <= r_perf_empty + 32'd1;
            end
            if (redirect_valid && (r_perf_redir != '1)) begin
                r_perf_redir <= r_perf_redir + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_empty_cycles = r_perf_empty;
    assign perf_redirects    = r_perf_redir;
`endif

endmodule
`default_nettype wire
